exe_mul_sequencer: RTL and testbench

//  Multi-cycle MUL/MLA controller for the EXE stage. Borrows the single EXE ALU and runs a

---
 rtl/exe_pkg.sv | 19 +
 rtl/mul_shift_regs.sv | 36 +++
 rtl/exe_mul_sequencer.sv | 152 +++++++++++++++
 tb/tb_exe_mul_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: ALU command encodings, the MUL sequencer
// state enum and the bit positions inside the {N,Z,C,V} status word.
package exe_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_ADD = 4'b0010;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_shift_regs.sv
// Multiplicand/multiplier shift registers and iteration counter for the
// shift-and-add multiply loop. Loaded at issue, advanced once per step.
module mul_shift_regs
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] mplr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= op_a;
            mplr  <= op_b;
            cnt   <= '0;
        end else if (step) begin
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/exe_mul_sequencer.sv
// Multi-cycle MUL/MLA controller: borrows the shared EXE ALU for a
// shift-and-add loop, stalls the pipeline meanwhile, optionally updates N/Z.
module exe_mul_sequencer
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    input  logic             abort,
    input  logic [3:0]       nzcv_in,
    input  logic [WIDTH-1:0] alu_result,
    output logic             alu_own,
    output logic [3:0]       alu_cmd,
    output logic [WIDTH-1:0] alu_inp1,
    output logic [WIDTH-1:0] alu_inp2,
    output logic             alu_carry,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flags_we,
    output logic [3:0]       nzcv_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    mul_state_t state, state_nxt;

    logic [WIDTH-1:0] mcand, mplr, acc, result_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cv;
    logic [3:0]       nzcv_q, nzcv_fin;
    logic             sflag, load, step, commit, finish;
    logic             unused_nz;

    assign unused_nz = nzcv_in[N_BIT] ^ nzcv_in[Z_BIT];

    mul_shift_regs #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .op_a (op_a),
        .op_b (op_b),
        .mcand(mcand),
        .mplr (mplr),
        .cnt  (cnt)
    );

    // Loop ends early once no multiplier bits remain.
    assign finish = (mplr == '0) || (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        alu_own   = 1'b0;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                alu_own = 1'b1;
                stall   = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (finish) begin
                    state_nxt = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                stall     = 1'b1;
                state_nxt = ST_IDLE;
                if (!abort) begin
                    commit = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            sflag <= 1'b0;
            cv    <= 2'b00;
        end else if (load) begin
            acc   <= accumulate ? op_acc : '0;
            sflag <= set_flags;
            cv    <= {nzcv_in[C_BIT], nzcv_in[V_BIT]};
        end else if (step && mplr[0]) begin
            acc <= alu_result;
        end
    end

    always_comb begin
        nzcv_fin        = 4'b0000;
        nzcv_fin[N_BIT] = acc[WIDTH-1];
        nzcv_fin[Z_BIT] = (acc == '0);
        nzcv_fin[C_BIT] = cv[1];
        nzcv_fin[V_BIT] = cv[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            nzcv_q   <= 4'b0000;
        end else if (commit) begin
            result_q <= acc;
            nzcv_q   <= nzcv_fin;
        end
    end

    // Bypass the final value during the done pulse so result is valid with done.
    assign result    = commit ? acc : result_q;
    assign nzcv_out  = commit ? nzcv_fin : nzcv_q;
    assign done      = commit;
    assign flags_we  = commit & sflag;
    assign alu_cmd   = alu_own ? EXE_ADD : EXE_NOP;
    assign alu_inp1  = acc;
    assign alu_inp2  = mcand;
    assign alu_carry = 1'b0;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Self-checking bench for exe_mul_sequencer with a behavioural ALU and a
// scoreboard of expected products, flags and latencies.
module tb_exe_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, accumulate, set_flags, abort;
    logic [31:0] op_a, op_b, op_acc, alu_result;
    logic [3:0]  nzcv_in;
    logic        alu_own, alu_carry, stall, done, flags_we;
    logic [3:0]  alu_cmd, nzcv_out;
    logic [31:0] alu_inp1, alu_inp2, result;

    int n_tests = 0;
    int n_fail  = 0;
    int stall0;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic        fwe;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    exe_mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
        .set_flags(set_flags), .op_a(op_a), .op_b(op_b), .op_acc(op_acc),
        .abort(abort), .nzcv_in(nzcv_in), .alu_result(alu_result),
        .alu_own(alu_own), .alu_cmd(alu_cmd), .alu_inp1(alu_inp1),
        .alu_inp2(alu_inp2), .alu_carry(alu_carry), .stall(stall),
        .done(done), .result(result), .flags_we(flags_we), .nzcv_out(nzcv_out)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared EXE ALU
    assign alu_result = (alu_cmd == 4'b0010) ? alu_inp1 + alu_inp2 : 32'h0;

    function automatic exp_t model(input logic [31:0] a, b, c, input logic mla, s,
                                   input logic [3:0] nz);
        exp_t e;
        int k = 0;
        e.res = a * b + (mla ? c : 32'h0);
        e.nzcv = {e.res[31], e.res == 32'h0, nz[1:0]};
        e.fwe = s;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        e.lat = k + 2;
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, b, c, input logic mla, s,
                         input logic [3:0] nz);
        op_a = a; op_b = b; op_acc = c; accumulate = mla; set_flags = s;
        nzcv_in = nz; start = 1'b1;
        @(negedge clk);
        stall0 = int'(stall);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] r,
                             output logic [3:0] n, output logic fwe,
                             output int stall_cnt, output int own_cnt);
        lat = -1; r = 'x; n = 'x; fwe = 'x; stall_cnt = 0; own_cnt = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            stall_cnt += int'(stall);
            own_cnt   += int'(alu_own);
            if (done) begin
                lat = cyc; r = result; n = nzcv_out; fwe = flags_we;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; abort = 0; accumulate = 0; set_flags = 0;
        op_a = 0; op_b = 0; op_acc = 0; nzcv_in = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({alu_own, stall, done, flags_we, alu_carry} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL reset_ctrl got %b want 00000", {alu_own, stall, done, flags_we, alu_carry});
        end
        n_tests++;
        if (result !== 32'h0 || nzcv_out !== 4'h0 || alu_cmd !== 4'h0) begin
            n_fail++; $display("[TB] FAIL reset_data got res=%h nzcv=%b cmd=%b want 0", result, nzcv_out, alu_cmd);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_check(input string name, input logic [31:0] a, b, c,
                             input logic mla, s, input logic [3:0] nz,
                             input int want_stall, input int want_own);
        exp_t e;
        int lat, sc, oc;
        logic [31:0] r;
        logic [3:0] n;
        logic f;
        exp_q.push_back(model(a, b, c, mla, s, nz));
        issue(a, b, c, mla, s, nz);
        wait_done(lat, r, n, f, sc, oc);
        e = exp_q.pop_front();
        last_res = e.res;
        n_tests++;
        if (lat !== e.lat) begin n_fail++; $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, e.lat); end
        n_tests++;
        if (r !== e.res) begin n_fail++; $display("[TB] FAIL %s_result got %h want %h", name, r, e.res); end
        n_tests++;
        if (n !== e.nzcv || f !== e.fwe) begin
            n_fail++; $display("[TB] FAIL %s_flags got nzcv=%b we=%b want nzcv=%b we=%b", name, n, f, e.nzcv, e.fwe);
        end
        if (want_stall >= 0) begin
            n_tests++;
            if (stall0 != 1 || sc != want_stall || stall !== 1'b0) begin
                n_fail++; $display("[TB] FAIL %s_stall got s0=%0d cnt=%0d after=%b want 1 %0d 0", name, stall0, sc, stall, want_stall);
            end
        end
        if (want_own >= 0) begin
            n_tests++;
            if (oc != want_own) begin n_fail++; $display("[TB] FAIL %s_alu_own got %0d want %0d", name, oc, want_own); end
        end
    endtask

    task automatic test_mul_basic;
        run_check("mul3x5", 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'b0000, 5, 4);
    endtask

    task automatic test_mla_zero;
        run_check("mla_b0", 32'd7, 32'd0, 32'd100, 1'b1, 1'b0, 4'b0000, 2, 1);
    endtask

    task automatic test_msb_flags;
        run_check("msb", 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 4'b0011, 34, 33);
    endtask

    task automatic test_zero_flags;
        run_check("zero", 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b1, 4'b1100, 19, 18);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b, c;
            a = $urandom;
            b = 32'($urandom_range(1, 4095)) << $urandom_range(0, 8);
            c = $urandom;
            run_check("b2b", a, b, c, 1'($urandom), 1'($urandom), 4'($urandom), -1, -1);
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        issue(32'd2, 32'hFF, 32'd0, 1'b0, 1'b1, 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_tests++;
        if (stall !== 1'b0 || alu_own !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_idle got stall=%b own=%b want 0 0", stall, alu_own);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || flags_we) dones++;
        end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("[TB] FAIL abort_no_done got %0d want 0", dones); end
        n_tests++;
        if (result !== last_res) begin n_fail++; $display("[TB] FAIL abort_result got %h want %h", result, last_res); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        issue(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({alu_own, stall, done, flags_we} !== 4'b0 || result !== 32'h0 || nzcv_out !== 4'h0) begin
            n_fail++; $display("[TB] FAIL reset_mid got ctrl=%b res=%h nzcv=%b want 0", {alu_own, stall, done, flags_we}, result, nzcv_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_check("reissue9x9", 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'b0000, 6, 5);
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mla_zero();
        test_msb_flags();
        test_zero_flags();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
